// File: rtl/text_ram_arbiter_if.sv
// Host port bundle for the text RAM arbiter.
//   host_req   : host asks for a transaction, held until host_ack
//   host_we    : 1 = write, 0 = read (sampled when the request is accepted)
//   host_addr  : cell address {row[4:0], col[4:0]}
//   host_wdata : write byte
//   host_ack   : 1-cycle completion pulse
//   host_rdata : read byte, valid with host_ack and held until the next read
// Modport master = host side, slave = arbiter side.
interface text_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// Shares the single-port text RAM (registered 1-cycle read) between video
// scanout and a host port / clear-screen sequencer. Video owns the RAM while
// vid_active=1 and is never delayed; host and clear traffic only use blanking.
// Ports:
//   clk, reset         : system clock, asynchronous active-low reset
//   vid_active         : 1 = video owns the RAM this cycle
//   vid_addr/vid_data  : scanout address and the RAM output one cycle later
//   host (slave)       : req/ack host transaction port
//   clear_start        : pulse, fill the whole RAM with CLEAR_VAL
//   clear_busy         : clear pending or in progress
//   ram_addr/din/we    : to the RAM
//   ram_dout           : from the RAM
//
// state   | meaning
// IDLE    | waiting for a clear or host request (blanking only)
// WR      | host write driven onto the RAM
// RD      | host read address driven onto the RAM
// RD_DATA | RAM output captured into host_rdata
// ACK     | host_ack pulse
// CLEAR   | writing CLEAR_VAL at clr_cnt, one cell per blanking cycle
module text_ram_arbiter #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  text_ram_arbiter_if.slave host,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_DATA = 3'd3,
    ACK     = 3'd4,
    CLEAR   = 3'd5
  } state_t;

  state_t            state_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              clear_pend_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              host_we_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_wdata_q;
  logic              clear_req;

  assign clear_busy = clear_pend_q | (state_q == CLEAR);

  // A fresh clear_start is acted on in the same cycle when IDLE can take it,
  // so the sequencer enters CLEAR on the next cycle and busy covers exactly
  // the write cycles. Otherwise it is remembered in clear_pend_q.
  assign clear_req = clear_pend_q | (clear_start & ~clear_busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      clear_pend_q <= 1'b0;
      clr_cnt_q    <= '0;
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
    end else begin
      host_ack_q <= 1'b0;
      if (clear_start && !clear_busy) clear_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (!vid_active) begin
            if (clear_req) begin
              state_q      <= CLEAR;
              clr_cnt_q    <= '0;
              clear_pend_q <= 1'b0;
            end else if (host.host_req) begin
              host_we_q    <= host.host_we;
              host_addr_q  <= host.host_addr;
              host_wdata_q <= host.host_wdata;
              state_q      <= host.host_we ? WR : RD;
            end
          end
        end
        WR: begin
          if (!vid_active) begin
            state_q    <= ACK;
            host_ack_q <= 1'b1;
          end
        end
        RD: begin
          if (!vid_active) state_q <= RD_DATA;
        end
        RD_DATA: begin
          // The read was issued in RD, so ram_dout holds it regardless of video.
          host_rdata_q <= ram_dout;
          state_q      <= ACK;
          host_ack_q   <= 1'b1;
        end
        ACK: begin
          state_q <= IDLE;
        end
        CLEAR: begin
          if (!vid_active) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = vid_addr;
    ram_din  = host_wdata_q;
    if (!vid_active) begin
      case (state_q)
        WR: begin
          ram_we   = 1'b1;
          ram_addr = host_addr_q;
        end
        RD: ram_addr = host_addr_q;
        CLEAR: begin
          ram_we   = 1'b1;
          ram_addr = clr_cnt_q;
          ram_din  = CLEAR_VAL;
        end
        default: ;
      endcase
    end
  end

  assign vid_data        = ram_dout;
  assign host.host_ack   = host_ack_q;
  assign host.host_rdata = host_rdata_q;

  // host_we_q only steers WR/RD at acceptance; kept as the latched copy.
  logic unused_we;
  assign unused_we = host_we_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
module tb_text_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_active;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          clear_start;
  logic          clear_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_we;

  int total = 0;
  int bad   = 0;

  text_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

  text_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .vid_active  (vid_active),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .host        (hif),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model with a bench-side fill port that overrides the DUT.
  logic [DW-1:0] mem [1024];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_din;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_din;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(int i);
    return 8'h80 | 8'(i % 128);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 1024; i++) begin
      tb_we   = 1'b1;
      tb_addr = 10'(i);
      tb_din  = pat(i);
      cyc();
    end
    tb_we = 1'b0;
  endtask

  // Cells below split must be cleared, the rest must hold the fill pattern.
  task automatic sweep(string tag, int split);
    int n;
    logic [7:0] e;
    n = 0;
    for (int i = 0; i < 1024; i++) begin
      e = (i < split) ? 8'h00 : pat(i);
      if (mem[i] !== e) n++;
    end
    chk(tag, 32'(n), 32'd0);
  endtask

  task automatic host_xact(input logic we, input logic [9:0] a, input logic [7:0] wd,
                           output int lat, output int wecnt, output logic [9:0] wa,
                           output logic [7:0] wdv, output logic [7:0] rd);
    cyc();
    hif.host_req   = 1'b1;
    hif.host_we    = we;
    hif.host_addr  = a;
    hif.host_wdata = wd;
    lat = -1; wecnt = 0; wa = '0; wdv = '0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (ram_we) begin
        wecnt++;
        wa  = ram_addr;
        wdv = ram_din;
      end
      if (hif.host_ack) begin
        lat = i;
        rd  = hif.host_rdata;
        break;
      end
    end
    hif.host_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wecnt, err, n_busy, n_we, e, found, first;
    int err_ord, err_vid, err_vd, prev_e;
    logic seen, prev_on;
    logic [9:0] wa, prev_vaddr;
    logic [7:0] wdv, rd, ev;

    reset = 1'b0; vid_active = 1'b0; vid_addr = 10'h123; clear_start = 1'b0;
    tb_we = 1'b0; tb_addr = '0; tb_din = '0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    repeat (3) cyc();
    chk("rst_ack",      32'(hif.host_ack),   32'd0);
    chk("rst_rdata",    32'(hif.host_rdata), 32'd0);
    chk("rst_busy",     32'(clear_busy),     32'd0);
    chk("rst_we",       32'(ram_we),         32'd0);
    chk("rst_ram_addr", 32'(ram_addr),       32'h123);
    reset = 1'b1;
    fill();

    // blanking write then read of the last cell
    host_xact(1'b1, 10'h3FF, 8'hA5, lat, wecnt, wa, wdv, rd);
    chk("wr_lat",   32'(lat),   32'd2);
    chk("wr_we_n",  32'(wecnt), 32'd1);
    chk("wr_addr",  32'(wa),    32'h3FF);
    chk("wr_din",   32'(wdv),   32'hA5);
    chk("wr_mem",   32'(mem[10'h3FF]), 32'hA5);
    host_xact(1'b0, 10'h3FF, 8'h00, lat, wecnt, wa, wdv, rd);
    chk("rd_lat",   32'(lat),   32'd3);
    chk("rd_we_n",  32'(wecnt), 32'd0);
    chk("rd_data",  32'(rd),    32'hA5);
    host_xact(1'b0, 10'h012, 8'h00, lat, wecnt, wa, wdv, rd);
    chk("rd2_data", 32'(rd),    32'h92);

    // write accepted in blanking, then stalled in WR by video
    cyc();
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 10'h0AA; hif.host_wdata = 8'h3C;
    cyc();
    vid_active = 1'b1;
    err = 0;
    for (int k = 0; k < 5; k++) begin
      vid_addr = 10'(k * 3 + 200);
      #1;
      if (ram_we !== 1'b0 || ram_addr !== vid_addr || hif.host_ack !== 1'b0) err++;
      cyc();
    end
    vid_active = 1'b0;
    #1;
    chk("stall_resume_we", 32'(ram_we), 32'd1);
    cyc();
    chk("stall_ack", 32'(hif.host_ack), 32'd1);
    hif.host_req = 1'b0;
    chk("stall_err", 32'(err), 32'd0);
    chk("stall_mem", 32'(mem[10'h0AA]), 32'h3C);

    // request held through 50 cycles of video
    cyc();
    vid_active = 1'b1;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 10'h155; hif.host_wdata = 8'h77;
    err = 0;
    for (int k = 0; k < 50; k++) begin
      vid_addr = 10'((k * 37) % 1024);
      #1;
      if (ram_we !== 1'b0 || ram_addr !== vid_addr) err++;
      cyc();
    end
    vid_active = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (hif.host_ack) begin lat = i; break; end
    end
    hif.host_req = 1'b0;
    chk("vid_hold_err", 32'(err), 32'd0);
    chk("vid_hold_lat", 32'(lat), 32'd2);
    chk("vid_hold_mem", 32'(mem[10'h155]), 32'h77);
    chk("rdata_held",   32'(hif.host_rdata), 32'h92);

    // clear in blanking
    cyc();
    clear_start = 1'b1;
    n_busy = 0; n_we = 0; err = 0;
    for (int i = 1; i <= 1100; i++) begin
      cyc();
      clear_start = 1'b0;
      if (clear_busy) n_busy++;
      if (ram_we) begin
        if (ram_addr !== 10'(n_we) || ram_din !== 8'h00) err++;
        n_we++;
      end
      if (!clear_busy) break;
    end
    chk("clr_busy_cycles", 32'(n_busy), 32'd1024);
    chk("clr_writes",      32'(n_we),   32'd1024);
    chk("clr_order",       32'(err),    32'd0);
    sweep("clr_sweep", 1024);
    host_xact(1'b0, 10'h3FF, 8'h00, lat, wecnt, wa, wdv, rd);
    chk("clr_rd_3ff", 32'(rd), 32'h00);

    // clear and host request in the same cycle: clear wins
    cyc();
    clear_start = 1'b1;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 10'h2AA; hif.host_wdata = 8'h99;
    lat = -1; n_we = 0;
    for (int i = 1; i <= 1200; i++) begin
      cyc();
      clear_start = 1'b0;
      if (ram_we) n_we++;
      if (hif.host_ack) begin lat = i; break; end
    end
    hif.host_req = 1'b0;
    chk("race_lat",    32'(lat),  32'd1027);
    chk("race_writes", 32'(n_we), 32'd1025);
    chk("race_mem",    32'(mem[10'h2AA]), 32'h99);

    // clear with video 8 on / 2 off, requested during an on cycle
    fill();
    e = 0; err_ord = 0; err_vid = 0; err_vd = 0; prev_e = 0;
    seen = 1'b0; prev_on = 1'b0; prev_vaddr = '0;
    for (int k = 0; k < 8000; k++) begin
      vid_active  = ((k % 10) < 8);
      vid_addr    = 10'((k * 13 + 5) % 1024);
      clear_start = (k == 3);
      #1;
      if (vid_active) begin
        if (ram_we !== 1'b0 || ram_addr !== vid_addr) err_vid++;
      end else if (ram_we) begin
        if (ram_addr !== 10'(e) || ram_din !== 8'h00) err_ord++;
        e++;
      end
      if (prev_on) begin
        ev = (int'(prev_vaddr) < prev_e) ? 8'h00 : pat(int'(prev_vaddr));
        if (vid_data !== ev) err_vd++;
      end
      prev_on    = vid_active;
      prev_vaddr = vid_addr;
      prev_e     = e;
      if (clear_busy) seen = 1'b1;
      else if (seen) break;
      cyc();
    end
    clear_start = 1'b0;
    vid_active  = 1'b0;
    chk("tog_seen_busy", 32'(seen),    32'd1);
    chk("tog_writes",    32'(e),       32'd1024);
    chk("tog_order",     32'(err_ord), 32'd0);
    chk("tog_vid_mux",   32'(err_vid), 32'd0);
    chk("tog_vid_data",  32'(err_vd),  32'd0);
    sweep("tog_sweep", 1024);

    // reset in the middle of a clear
    fill();
    clear_start = 1'b1;
    found = 0;
    for (int i = 1; i <= 1100; i++) begin
      cyc();
      clear_start = 1'b0;
      if (ram_we && ram_addr == 10'h100) begin found = 1; break; end
    end
    chk("rst_mid_found", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(clear_busy), 32'd0);
    chk("rst_mid_we",   32'(ram_we),     32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    sweep("rst_mid_sweep", 256);
    cyc();
    clear_start = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      clear_start = 1'b0;
      if (ram_we) begin first = int'(ram_addr); break; end
    end
    chk("restart_addr", 32'(first), 32'd0);
    for (int i = 1; i <= 1100; i++) begin
      cyc();
      if (!clear_busy) break;
    end
    chk("restart_done", 32'(clear_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
